uart_btn_msg_src: RTL and testbench
===================================

Name: uart_btn_msg_src

Overview:
Parametrised successor to the button-to-UART configuration source. It debounces NUM_BTN active-low buttons and queues each press. Each press is streamed as a byte message (BASE_CHAR+index, optionally followed by CR LF) to the UART transmitter over a valid/ready handshake. It also drives the UART baud divisor ubrr from a runtime baud selector, for a 3.6864 MHz system clock.

Parameters:
NUM_BTN, 4, number of button inputs (1..8)
DEB_CYCLES, 36864, stable cycles needed to accept a level change (10 ms at 3.6864 MHz); must be >= 2
CNT_W, 16, debounce counter width; must hold DEB_CYCLES-1
BASE_CHAR, 65, byte sent for button 0; button i sends BASE_CHAR+i, mod 256
APPEND_CRLF, 1, 1 = each message is char,0x0D,0x0A; 0 = char only

Ports:
clk  input  1  system clock, 3.6864 MHz
rst  input  1  reset; one clock; reset is synchronous and active-low
btn  input  NUM_BTN  raw buttons, active-low, asynchronous to clk
baud_sel  input  2  0=9600, 1=19200, 2=38400, 3=115200
ubrr  output  12  baud divisor to UART core
tx_data  output  8  byte to transmitter
tx_valid  output  1  tx_data valid
tx_ready  input  1  transmitter accepts byte when tx_valid&tx_ready at posedge
busy  output  1  message in progress (state != IDLE)

Behaviour:
- Reset, rst=0 sampled at posedge: ubrr=0, tx_data=0, tx_valid=0, busy=0. Sync flops=all 1, stable levels=all 1 (released), counters=0, pending=0, state=IDLE. A reset mid-message aborts it: tx_valid drops at that edge and pending presses are lost.
- ubrr is registered. In IDLE with pending==0 it loads the table from baud_sel: 0->23, 1->11, 2->5, 3->1 (f/(16*baud)-1), with 1-cycle latency. Otherwise ubrr holds, so no baud change occurs mid-message.
- Per button: 2-flop synchroniser (sync2 valid after edge 2), then a debounce counter.
  - If sync2==stable: count<=0.
  - Else if count==DEB_CYCLES-1: stable<=sync2 and count<=0.
  - Else: count<=count+1.
  - Any bounce shorter than DEB_CYCLES resets the counter and produces no event.
- A press event is stable 1->0. Releases produce no event.
- Press event for button i sets pending[i] on the next edge. A second press while pending[i] is already set is dropped. If set and clear of the same bit fall in the same cycle, set wins.
- Latency: btn[i] held low from edge 0 gives stable low after edge DEB_CYCLES+2, pending after edge DEB_CYCLES+3, and tx_valid=1 after edge DEB_CYCLES+4.
- FSM states: IDLE, CHAR, CR, LF.
  - IDLE: if pending!=0, pick lowest set index i, clear pending[i], set tx_data=BASE_CHAR+i and tx_valid=1, go to CHAR.
  - CHAR: on handshake, if APPEND_CRLF=1 then tx_data=0x0D and go to CR; else tx_valid=0 and go to IDLE.
  - CR: on handshake, tx_data=0x0A and go to LF.
  - LF: on handshake, tx_valid=0 and go to IDLE.
  - With no handshake, state, tx_data and tx_valid hold.
- tx_valid never deasserts without a handshake except on reset. Consecutive message bytes are back-to-back: no idle cycle between bytes of one message. At least one IDLE cycle separates messages (tx_valid low for at least 1 cycle).
- Presses arriving during a message are queued in pending and served afterwards in index order. A press of the button currently being sent is queued and re-sent.
- busy = (state != IDLE), registered with state.

Test Plan:
(Bench parameters: DEB_CYCLES=8, NUM_BTN=4, APPEND_CRLF=1, tx_ready=1 unless stated.)
1. Reset, baud_sel=0, then baud_sel=3 while idle -> ubrr=0 during reset, 23 one cycle after release, 1 one cycle after the switch.
2. btn[0] held low -> tx_valid rises after edge 12. Bytes 0x41, 0x0D, 0x0A are accepted on 3 consecutive edges, then tx_valid=0 and busy=0.
3. btn[1] glitches low for 5 cycles, then high -> no pending and no tx_valid. A 20-cycle press -> exactly one 0x42,0x0D,0x0A message. The release causes nothing.
4. btn[2] and btn[0] pressed in the same cycle, tx_ready toggling 1/0 -> message 0x41 then 0x43. tx_data is stable while tx_ready=0. One IDLE cycle separates the messages.
5. baud_sel changed 0->2 during a message, plus btn[3] pressed twice mid-message -> ubrr stays 23 until IDLE with no pending, then 5. Only one 0x44 message is sent (duplicate dropped).
6. rst=0 asserted while state=CR with pending[1]=1 -> after that edge tx_valid=0, busy=0, ubrr=0. After release nothing is sent until a new press.

Source files
------------

// File: rtl/uart_btn_msg_src.sv
// rtl/uart_btn_msg_src.sv - debounced buttons queued as UART byte messages, plus baud divisor select
module uart_btn_msg_src #(
  parameter int NUM_BTN     = 4,
  parameter int DEB_CYCLES  = 36864,
  parameter int CNT_W       = 16,
  parameter int BASE_CHAR   = 65,
  parameter int APPEND_CRLF = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn,
  input  logic [1:0]         baud_sel,
  output logic [11:0]        ubrr,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, CHAR, CR, LF} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] stable;
  logic [NUM_BTN-1:0] stable_d;
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] pending;
  logic [NUM_BTN-1:0] pending_next;
  logic [NUM_BTN-1:0] clr;
  logic [NUM_BTN-1:0] pick_mask;
  logic [7:0]         pick_char;
  logic [CNT_W-1:0]   cnt [NUM_BTN];

  state_t      state;
  state_t      state_next;
  logic [7:0]  data_next;
  logic        valid_next;
  logic [11:0] ubrr_next;
  logic        hs;

  // Synchronise the raw buttons and accept a level only after it has held for DEB_CYCLES
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1    <= '1;
      sync2    <= '1;
      stable   <= '1;
      stable_d <= '1;
      for (int i = 0; i < NUM_BTN; i++) cnt[i] <= '0;
    end else begin
      sync1    <= btn;
      sync2    <= sync1;
      stable_d <= stable;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // A press is the debounced level falling; releases are ignored
  assign press = stable_d & ~stable;
  assign hs    = tx_valid & tx_ready;

  // Lowest-numbered pending button wins arbitration
  always_comb begin
    pick_char = 8'(BASE_CHAR);
    pick_mask = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (pending[i]) begin
        pick_char = 8'(BASE_CHAR + i);
        pick_mask = NUM_BTN'(1) << i;
      end
    end
  end

  // Message sequencer and baud table; ubrr only tracks baud_sel while fully idle
  always_comb begin
    state_next = state;
    data_next  = tx_data;
    valid_next = tx_valid;
    ubrr_next  = ubrr;
    clr        = '0;
    case (state)
      IDLE: begin
        if (pending != '0) begin
          clr        = pick_mask;
          data_next  = pick_char;
          valid_next = 1'b1;
          state_next = CHAR;
        end else begin
          case (baud_sel)
            2'd0:    ubrr_next = 12'd23;
            2'd1:    ubrr_next = 12'd11;
            2'd2:    ubrr_next = 12'd5;
            default: ubrr_next = 12'd1;
          endcase
        end
      end
      CHAR: begin
        if (hs) begin
          if (APPEND_CRLF != 0) begin
            data_next  = 8'h0D;
            state_next = CR;
          end else begin
            valid_next = 1'b0;
            state_next = IDLE;
          end
        end
      end
      CR: begin
        if (hs) begin
          data_next  = 8'h0A;
          state_next = LF;
        end
      end
      LF: begin
        if (hs) begin
          valid_next = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // A new press in the same cycle as the clear keeps the bit set
    pending_next = (pending & ~clr) | press;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      ubrr     <= '0;
      pending  <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      tx_data  <= data_next;
      tx_valid <= valid_next;
      ubrr     <= ubrr_next;
      pending  <= pending_next;
      busy     <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_btn_msg_src.sv
// tb/tb_uart_btn_msg_src.sv - scoreboard bench for uart_btn_msg_src
module tb_uart_btn_msg_src;

  logic        clk;
  logic        rst;
  logic [3:0]  btn;
  logic [1:0]  baud_sel;
  logic [11:0] ubrr;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] sb [$];

  uart_btn_msg_src #(
    .NUM_BTN(4), .DEB_CYCLES(8), .CNT_W(4), .BASE_CHAR(65), .APPEND_CRLF(1)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn), .baud_sel(baud_sel), .ubrr(ubrr),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it disagrees
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_msg(input logic [7:0] c);
    sb.push_back(c);
    sb.push_back(8'h0D);
    sb.push_back(8'h0A);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!tx_valid && n < budget) begin
      step(1);
      n++;
    end
    check_eq("wait_valid", {31'd0, tx_valid}, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy || tx_valid) && n < budget) begin
      step(1);
      n++;
    end
    check_eq("drain_left", sb.size(), 32'd0);
    check_eq("drain_busy", {31'd0, busy}, 32'd0);
  endtask

  // Output monitor: every valid byte must be the scoreboard head; valid may not drop unaccepted
  logic held_v   = 1'b0;
  logic after_lf = 1'b0;
  always @(negedge clk) begin
    logic [31:0] exp;
    if (!rst) begin
      held_v   = 1'b0;
      after_lf = 1'b0;
    end else begin
      if (after_lf) begin
        check_eq("msg_gap_valid", {31'd0, tx_valid}, 32'd0);
        after_lf = 1'b0;
      end
      if (held_v) check_eq("valid_dropped", {31'd0, tx_valid}, 32'd1);
      held_v = tx_valid && !tx_ready;
      if (tx_valid) begin
        if (sb.size() > 0) exp = {24'd0, sb[0]};
        else exp = 32'h100;
        check_eq("tx_data", {24'd0, tx_data}, exp);
        if (tx_ready) begin
          if (sb.size() > 0) void'(sb.pop_front());
          if (tx_data == 8'h0A) after_lf = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; btn = 4'hF; baud_sel = 2'd0; tx_ready = 1'b1;

    // 1: reset values and baud table
    step(3);
    check_eq("rst_ubrr", {20'd0, ubrr}, 32'd0);
    check_eq("rst_valid", {31'd0, tx_valid}, 32'd0);
    check_eq("rst_data", {24'd0, tx_data}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    step(1);
    check_eq("ubrr_9600", {20'd0, ubrr}, 32'd23);
    baud_sel = 2'd3;
    step(1);
    check_eq("ubrr_115200", {20'd0, ubrr}, 32'd1);
    baud_sel = 2'd0;
    step(1);
    check_eq("ubrr_back", {20'd0, ubrr}, 32'd23);

    // 2: latency of a single press and back-to-back bytes
    push_msg(8'h41);
    btn[0] = 1'b0;
    step(11);
    check_eq("lat_early", {31'd0, tx_valid}, 32'd0);
    step(1);
    check_eq("lat_valid", {31'd0, tx_valid}, 32'd1);
    check_eq("lat_busy", {31'd0, busy}, 32'd1);
    step(3);
    check_eq("b2b_valid", {31'd0, tx_valid}, 32'd0);
    check_eq("b2b_busy", {31'd0, busy}, 32'd0);
    check_eq("b2b_left", sb.size(), 32'd0);
    btn[0] = 1'b1;
    step(20);

    // 3: short glitch ignored, one long press gives one message
    btn[1] = 1'b0;
    step(5);
    btn[1] = 1'b1;
    step(20);
    check_eq("glitch_valid", {31'd0, tx_valid}, 32'd0);
    check_eq("glitch_busy", {31'd0, busy}, 32'd0);
    push_msg(8'h42);
    btn[1] = 1'b0;
    step(20);
    btn[1] = 1'b1;
    wait_idle(40);
    step(20);
    check_eq("release_quiet", {31'd0, tx_valid}, 32'd0);

    // 4: simultaneous presses, lowest index first, with backpressure
    push_msg(8'h41);
    push_msg(8'h43);
    btn[0] = 1'b0;
    btn[2] = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          tx_ready = ~tx_ready;
          step(1);
        end
        tx_ready = 1'b1;
      end
      begin
        step(20);
        btn[0] = 1'b1;
        btn[2] = 1'b1;
      end
    join
    wait_idle(60);
    step(20);

    // 5: baud change and duplicate press held off during a message
    tx_ready = 1'b0;
    push_msg(8'h41);
    push_msg(8'h44);
    btn[0] = 1'b0;
    wait_valid(20);
    baud_sel = 2'd2;
    step(1);
    check_eq("ubrr_hold_a", {20'd0, ubrr}, 32'd23);
    btn[3] = 1'b0;
    step(14);
    btn[3] = 1'b1;
    btn[0] = 1'b1;
    step(14);
    btn[3] = 1'b0;
    step(14);
    btn[3] = 1'b1;
    step(14);
    check_eq("ubrr_hold_b", {20'd0, ubrr}, 32'd23);
    tx_ready = 1'b1;
    wait_idle(40);
    step(1);
    check_eq("ubrr_38400", {20'd0, ubrr}, 32'd5);
    step(20);
    check_eq("dup_dropped", {31'd0, tx_valid}, 32'd0);

    // 6: reset mid-message while another press is pending
    tx_ready = 1'b0;
    push_msg(8'h41);
    btn[0] = 1'b0;
    btn[1] = 1'b0;
    wait_valid(20);
    tx_ready = 1'b1;
    step(1);
    tx_ready = 1'b0;
    check_eq("cr_data", {24'd0, tx_data}, 32'h0D);
    check_eq("cr_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    btn = 4'hF;
    step(1);
    check_eq("abort_valid", {31'd0, tx_valid}, 32'd0);
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_ubrr", {20'd0, ubrr}, 32'd0);
    sb.delete();
    rst = 1'b1;
    tx_ready = 1'b1;
    step(30);
    check_eq("post_rst_valid", {31'd0, tx_valid}, 32'd0);
    check_eq("post_rst_ubrr", {20'd0, ubrr}, 32'd5);
    push_msg(8'h43);
    btn[2] = 1'b0;
    step(20);
    btn[2] = 1'b1;
    wait_idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
